// File: rtl/marco_overlay.sv
// marco_overlay: frame border, three stacked boxes with 2x-scaled label and
// separator glyphs, a blinking selection highlight and a 2-stage colour pipe.
module marco_overlay #(
  parameter int          BORDER       = 11,
  parameter int          BOX_X0       = 160,
  parameter int          BOX_W        = 304,
  parameter int          BOX_Y0       = 32,
  parameter int          BOX_PITCH    = 160,
  parameter int          BOX_H        = 96,
  parameter int          THICK        = 16,
  parameter int          LBL_X0       = 96,
  parameter logic [29:0] LBL_CODES    = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2},
  parameter int          SEP_X0       = 256,
  parameter int          SEP_X1       = 352,
  parameter logic [4:0]  SEP_CODE     = 5'b11010,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] BG_COLOR     = 12'h111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       frame_start,
  input  logic [1:0] sel,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [11:0] cfg_data,
  output logic [8:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [3:0] ro,
  output logic [3:0] go,
  output logic [3:0] bo,
  output logic       blink_phase
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  // Geometry scratch values
  int         px, py, top, gtop;
  logic       in_box, in_inner, in_band, hit;
  logic [4:0] code;
  logic [3:0] row;

  // Stage-1 next values and registers
  logic        vid_d, vid_q;
  logic        border_d, border_q;
  logic        frame_d, frame_q;
  logic        glyph_d, glyph_q;
  logic [1:0]  box_idx_d, box_idx_q;
  logic [2:0]  col_d, col_q;
  logic [11:0] border_col_d, border_col_q;
  logic [11:0] box_col_d, box_col_q;

  // Stage-2 colour
  logic        lit;
  logic [11:0] box_rgb;
  logic [11:0] rgb_d, rgb_q;

  // Control state
  logic [7:0]  blink_cnt_d, blink_cnt_q;
  logic        blink_phase_d, blink_phase_q;
  logic [1:0]  sel_d, sel_q;
  logic [11:0] colreg_d [4];
  logic [11:0] colreg_q [4];

  // Classify the current pixel into border / box frame / glyph cell and form the font address
  always_comb begin
    px        = int'(pixel_x);
    py        = int'(pixel_y);
    top       = 0;
    gtop      = 0;
    in_box    = 1'b0;
    in_inner  = 1'b0;
    in_band   = 1'b0;
    hit       = 1'b0;
    code      = '0;
    row       = '0;
    frame_d   = 1'b0;
    glyph_d   = 1'b0;
    box_idx_d = '0;
    border_d  = (px < 640) && (py < 480) &&
                ((px < BORDER) || (px >= 640 - BORDER) ||
                 (py < BORDER) || (py >= 480 - BORDER));
    for (int k = 0; k < 3; k++) begin
      top      = BOX_Y0 + k * BOX_PITCH;
      gtop     = top + 32;
      in_box   = (px >= BOX_X0) && (px <= BOX_X0 + BOX_W - 1) &&
                 (py >= top) && (py <= top + BOX_H - 1);
      in_inner = (px >= BOX_X0 + THICK) && (px <= BOX_X0 + BOX_W - 1 - THICK) &&
                 (py >= top + THICK) && (py <= top + BOX_H - 1 - THICK);
      in_band  = (py >= gtop) && (py <= gtop + 31);
      hit      = 1'b0;
      for (int j = 0; j < 2; j++) begin
        if (in_band && (px >= LBL_X0 + 32 * j) && (px <= LBL_X0 + 32 * j + 15)) begin
          hit  = 1'b1;
          code = LBL_CODES[(2 * k + j) * 5 +: 5];
        end
      end
      if ((k != 1) && in_band &&
          (((px >= SEP_X0) && (px <= SEP_X0 + 15)) ||
           ((px >= SEP_X1) && (px <= SEP_X1 + 15)))) begin
        hit  = 1'b1;
        code = SEP_CODE;
      end
      if (in_box && !in_inner) begin
        frame_d   = 1'b1;
        box_idx_d = 2'(k);
      end
      if (hit) begin
        glyph_d   = 1'b1;
        box_idx_d = 2'(k);
        row       = 4'((py - gtop) >> 1);
      end
    end
  end

  assign rom_addr = {code, row};

  // Snapshot colour registers at stage 1 so a same-cycle write only affects later pixels
  always_comb begin
    vid_d        = video_on;
    col_d        = pixel_x[3:1];
    border_col_d = colreg_q[0];
    box_col_d    = colreg_q[box_idx_d + 2'd1];
  end

  // Colour register write port
  always_comb begin
    colreg_d = colreg_q;
    if (cfg_we) begin
      colreg_d[cfg_addr] = cfg_data;
    end
  end

  // Blink counter and selection latch advance only at frame boundaries
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    sel_d         = sel_q;
    if (frame_start) begin
      sel_d = sel;
      if (blink_cnt_q >= BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // Stage-2 colour priority: blanking, edge border, box frame/lit glyph, background
  always_comb begin
    lit     = glyph_q && rom_data[3'd7 - col_q];
    box_rgb = box_col_q;
    if (blink_phase_q && (sel_q == box_idx_q + 2'd1)) begin
      box_rgb = ~box_col_q;
    end
    if (!vid_q) begin
      rgb_d = 12'h000;
    end else if (border_q) begin
      rgb_d = border_col_q;
    end else if (frame_q || lit) begin
      rgb_d = box_rgb;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  // All state registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_q         <= 1'b0;
      border_q      <= 1'b0;
      frame_q       <= 1'b0;
      glyph_q       <= 1'b0;
      box_idx_q     <= '0;
      col_q         <= '0;
      border_col_q  <= '0;
      box_col_q     <= '0;
      rgb_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sel_q         <= '0;
      colreg_q[0]   <= 12'h604;
      colreg_q[1]   <= 12'h001;
      colreg_q[2]   <= 12'h010;
      colreg_q[3]   <= 12'h100;
    end else begin
      vid_q         <= vid_d;
      border_q      <= border_d;
      frame_q       <= frame_d;
      glyph_q       <= glyph_d;
      box_idx_q     <= box_idx_d;
      col_q         <= col_d;
      border_col_q  <= border_col_d;
      box_col_q     <= box_col_d;
      rgb_q         <= rgb_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sel_q         <= sel_d;
      colreg_q      <= colreg_d;
    end
  end

  assign ro          = rgb_q[11:8];
  assign go          = rgb_q[7:4];
  assign bo          = rgb_q[3:0];
  assign blink_phase = blink_phase_q;

endmodule
